// File: rtl/multi_digit_scanner.sv
// Time-multiplexed driver for a multi-digit 7-segment display with per-digit
// enable, blanking dead time and frame-synchronous PWM brightness.
module multi_digit_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 65536,
  parameter int BLANK_CYCLES   = 256,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic                    frame_start
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic AN_OFF  = (AN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] C_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYCLES);
  localparam logic [DW-1:0] D_LAST  = DW'(NUM_DIGITS - 1);

  logic [CW-1:0]           c_q, c_d;
  logic [DW-1:0]           d_q, d_d;
  logic [7*NUM_DIGITS-1:0] sh_seg_q, sh_seg_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
  logic [3:0]              sh_bri_q, sh_bri_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    fs_q, fs_d;

  logic                    frame_edge_s;
  logic                    lit_s;
  logic [CW+3:0]           on_off_s;
  logic [3:0]              pwm_s;
  logic [NUM_DIGITS-1:0]   onehot_s;

  // Slot/digit sequencing, shadow capture and output decode
  always_comb begin
    c_d      = c_q;
    d_d      = d_q;
    sh_seg_d = sh_seg_q;
    sh_dp_d  = sh_dp_q;
    sh_en_d  = sh_en_q;
    sh_bri_d = sh_bri_q;
    an_d     = {NUM_DIGITS{AN_OFF}};
    seg_d    = {7{SEG_OFF}};
    dp_d     = SEG_OFF;

    frame_edge_s = (c_q == '0) && (d_q == '0);
    fs_d         = frame_edge_s;

    if (c_q == C_LAST) begin
      c_d = '0;
      if (d_q == D_LAST) begin
        d_d = '0;
      end else begin
        d_d = d_q + DW'(1);
      end
    end else begin
      c_d = c_q + CW'(1);
    end

    // Shadows only change at frame start so a frame never mixes old and new data
    if (frame_edge_s) begin
      sh_seg_d = seg_in;
      sh_dp_d  = dp_in;
      sh_en_d  = digit_en;
      sh_bri_d = brightness;
    end else begin
      sh_seg_d = sh_seg_q;
    end

    on_off_s = {4'b0000, c_q} - (CW+4)'(BLANK_CYCLES);
    pwm_s    = on_off_s[3:0];
    lit_s    = (c_q >= C_BLANK) && sh_en_q[d_q] && (pwm_s <= sh_bri_q);
    onehot_s = NUM_DIGITS'(1) << d_q;

    if (lit_s) begin
      an_d  = (AN_OFF == 1'b1) ? ~onehot_s : onehot_s;
      seg_d = sh_seg_q[d_q*7 +: 7];
      dp_d  = sh_dp_q[d_q];
    end else begin
      an_d  = {NUM_DIGITS{AN_OFF}};
    end
  end

  // State and registered outputs; reset drops every output to its dark level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q      <= '0;
      d_q      <= '0;
      sh_seg_q <= {(7*NUM_DIGITS){SEG_OFF}};
      sh_dp_q  <= {NUM_DIGITS{SEG_OFF}};
      sh_en_q  <= '0;
      sh_bri_q <= 4'd0;
      an_q     <= {NUM_DIGITS{AN_OFF}};
      seg_q    <= {7{SEG_OFF}};
      dp_q     <= SEG_OFF;
      fs_q     <= 1'b0;
    end else begin
      c_q      <= c_d;
      d_q      <= d_d;
      sh_seg_q <= sh_seg_d;
      sh_dp_q  <= sh_dp_d;
      sh_en_q  <= sh_en_d;
      sh_bri_q <= sh_bri_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      fs_q     <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg_out     = seg_q;
  assign dp_out      = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_multi_digit_scanner.sv
// Directed bench for multi_digit_scanner with NUM_DIGITS=4, TICK_DIV=8,
// BLANK_CYCLES=2, active-low anodes and segments.
module tb_multi_digit_scanner;

  logic        clk;
  logic        rst_n;
  logic [27:0] seg_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  brightness;
  logic [3:0]  an;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic        frame_start;

  int total = 0;
  int bad   = 0;

  logic [27:0] cfg_seg [5];
  logic [3:0]  cfg_dp  [5];
  logic [3:0]  cfg_en  [5];
  logic [3:0]  cfg_bri [5];

  multi_digit_scanner #(
    .NUM_DIGITS(4), .TICK_DIV(8), .BLANK_CYCLES(2),
    .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dp_in(dp_in),
    .digit_en(digit_en), .brightness(brightness), .an(an),
    .seg_out(seg_out), .dp_out(dp_out), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_cfg(input int f);
    seg_in     = cfg_seg[f];
    dp_in      = cfg_dp[f];
    digit_en   = cfg_en[f];
    brightness = cfg_bri[f];
  endtask

  // k = edges since frame 0 started; f = configuration held in the shadows
  task automatic check_cycle(input int k, input int f);
    int d, c;
    logic lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    logic [27:0] s;
    logic [3:0] en, dpv;
    d   = (k / 8) % 4;
    c   = k % 8;
    s   = cfg_seg[f];
    en  = cfg_en[f];
    dpv = cfg_dp[f];
    lit = (c >= 2) && en[d] && (((c - 2) % 16) <= int'(cfg_bri[f]));
    e_an  = lit ? ~(4'b0001 << d) : 4'b1111;
    e_seg = lit ? s[d*7 +: 7] : 7'h7F;
    e_dp  = lit ? dpv[d] : 1'b1;
    chk($sformatf("an@%0d", k), 32'(an), 32'(e_an));
    chk($sformatf("seg@%0d", k), 32'(seg_out), 32'(e_seg));
    chk($sformatf("dp@%0d", k), 32'(dp_out), 32'(e_dp));
    chk($sformatf("fs@%0d", k), 32'(frame_start), 32'((k % 32) == 0));
    chk($sformatf("onehot@%0d", k), 32'($countones(~an) <= 1), 32'd1);
  endtask

  initial begin
    int f;
    // frame 0: full brightness; frame 1: brightness 2; frame 2: digits 1,3 off;
    // frame 3: new glyphs at brightness 0; frame 4+: digit 1 off, all dp lit
    cfg_seg[0] = {7'h30, 7'h24, 7'h79, 7'h40}; cfg_dp[0] = 4'b1010; cfg_en[0] = 4'b1111; cfg_bri[0] = 4'd15;
    cfg_seg[1] = {7'h30, 7'h24, 7'h79, 7'h40}; cfg_dp[1] = 4'b1111; cfg_en[1] = 4'b1111; cfg_bri[1] = 4'd2;
    cfg_seg[2] = {7'h30, 7'h24, 7'h79, 7'h40}; cfg_dp[2] = 4'b1111; cfg_en[2] = 4'b0101; cfg_bri[2] = 4'd15;
    cfg_seg[3] = {7'h78, 7'h02, 7'h19, 7'h12}; cfg_dp[3] = 4'b1111; cfg_en[3] = 4'b1111; cfg_bri[3] = 4'd0;
    cfg_seg[4] = {7'h78, 7'h02, 7'h19, 7'h12}; cfg_dp[4] = 4'b0000; cfg_en[4] = 4'b1101; cfg_bri[4] = 4'd15;

    rst_n = 1'b0;
    apply_cfg(0);
    #12;
    chk("rst_an", 32'(an), 32'h0000000F);
    chk("rst_seg", 32'(seg_out), 32'h0000007F);
    chk("rst_dp", 32'(dp_out), 32'd1);
    chk("rst_fs", 32'(frame_start), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 340; k++) begin
      @(posedge clk);
      @(negedge clk);
      f = (k / 32 > 4) ? 4 : k / 32;
      check_cycle(k, f);
      if ((k % 32) == 10 && f < 4) apply_cfg(f + 1);
    end

    // k=340 is digit 2, slot cycle 4: lit with its dp active
    chk("pre_rst_an", 32'(an), 32'h0000000B);
    chk("pre_rst_dp", 32'(dp_out), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", 32'(an), 32'h0000000F);
    chk("async_rst_seg", 32'(seg_out), 32'h0000007F);
    chk("async_rst_dp", 32'(dp_out), 32'd1);
    chk("async_rst_fs", 32'(frame_start), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("held_rst_an", 32'(an), 32'h0000000F);
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk);
      @(negedge clk);
      check_cycle(j, 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_digit_scanner.md
MULTI_DIGIT_SCANNER -- requirements
Module: multi_digit_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, digit count (legal 2..8).
REQ-002 SHALL have parameter TICK_DIV, default 65536, clock cycles per digit slot (legal 4..2^20).
REQ-003 SHALL have parameter BLANK_CYCLES, default 256, all-anodes-off dead time at start of each slot (legal 1..TICK_DIV-1).
REQ-004 SHALL have parameter AN_ACTIVE_LOW, default 1, anode polarity (1 = low lights).
REQ-005 SHALL have parameter SEG_ACTIVE_LOW, default 1, cathode/dp polarity; seg_in/dp_in use the same polarity.
REQ-006 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-008 SHALL have port seg_in  input  7*NUM_DIGITS  segment patterns, digit k at [7k+6:7k], digit 0 rightmost.
REQ-009 SHALL have port dp_in  input  NUM_DIGITS  decimal point per digit.
REQ-010 SHALL have port digit_en  input  NUM_DIGITS  per-digit enable; 0 keeps that anode inactive for its slot.
REQ-011 SHALL have port brightness  input  4  PWM level during on-phase.
REQ-012 SHALL have port an  output  NUM_DIGITS  anodes, registered.
REQ-013 SHALL have port seg_out  output  7  cathodes, registered.
REQ-014 SHALL have port dp_out  output  1  decimal point, registered.
REQ-015 SHALL have port frame_start  output  1  one-cycle pulse marking start of each frame, registered.

Function
REQ-016 Slot counter c SHALL count 0..TICK_DIV-1 and wrap to 0; digit index d SHALL increment when c wraps, modulo NUM_DIGITS (NUM_DIGITS-1 -> 0).
REQ-017 Every digit SHALL get its slot regardless of digit_en (constant refresh rate, no skipping).
REQ-018 Shadow registers (seg, dp, en, brightness) SHALL load from inputs on every edge where c==0 and d==0 (frame start); inputs elsewhere SHALL be ignored (no tearing).
REQ-019 Slot phases: BLANK for c < BLANK_CYCLES; ON for c >= BLANK_CYCLES.
REQ-020 In ON, with p = (c - BLANK_CYCLES) mod 16, digit SHALL be lit iff shadow_en[d]==1 and p <= shadow_brightness (15 = full on, 0 = 1/16 duty).
REQ-021 Lit: an SHALL drive only bit d active, seg_out = shadow_seg[d], dp_out = shadow_dp[d].
REQ-022 Not lit (BLANK, disabled, or PWM off): an all inactive, seg_out and dp_out inactive level.
REQ-023 Outputs SHALL be registered: output after edge t reflects (c,d,shadow) state held before edge t; latency one cycle.
REQ-024 frame_start SHALL be 1 for exactly the cycle after the edge on which shadows load, else 0.
REQ-025 Never more than one anode active in any cycle, including across slot boundaries.
REQ-026 Inactive level SHALL be 1 when the corresponding ACTIVE_LOW parameter is 1, else 0.

Reset
REQ-027 rst_n low SHALL asynchronously force c=0, d=0, shadows to inactive (en=0, brightness=0, seg/dp inactive), an/seg_out/dp_out inactive, frame_start=0.
REQ-028 First rising edge with rst_n high SHALL load shadows (c==0, d==0) and pulse frame_start on the following cycle.
REQ-029 Reset asserted mid-slot or mid-frame SHALL abort immediately; no partial digit remains lit.

Verification (NUM_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2, active-low)
REQ-030 Release reset, seg_in digits 0..3 = 7'h40,7'h79,7'h24,7'h30, all en, brightness=15 -> per 8-cycle slot 2 cycles an=4'b1111 then 6 cycles an=1110/1101/1011/0111 with matching seg_out; frame_start every 32 cycles.
REQ-031 brightness=2 loaded at frame start -> each slot: 2 blank, 3 lit, 3 dark cycles.
REQ-032 digit_en=4'b0101 -> digits 1 and 3 slots show an=4'b1111, seg_out=7'h7F for all 8 cycles; period unchanged.
REQ-033 Change seg_in mid-frame -> display unchanged until next frame_start, new value visible from next frame's digit 0 on-phase.
REQ-034 Assert rst_n low during digit 2 on-phase -> an=4'b1111, seg_out=7'h7F, dp_out=1 immediately without clock; restart at digit 0.
REQ-035 Continuous check over 10 frames: an never has more than one active bit; frame_start width exactly 1.
